// File: rtl/irq_sequencer.sv
// irq_sequencer: 27-channel edge-triggered interrupt sequencer with mask, fixed priority and CPU handshake
// ports: ck/rst_n clock and sync active-low reset; irq_in request lines (bank*9+channel);
//        mask_we/mask_wdata mask load (1 = masked); int_ack/eoi CPU handshake;
//        int_req/int_vec request and latched vector; vec_valid acceptance strobe;
//        in_service servicing flag; bank_act per-bank eligible flag; pending edge-captured requests
module irq_sequencer #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [26:0] irq_in,
  input  logic        mask_we,
  input  logic [26:0] mask_wdata,
  input  logic        int_ack,
  input  logic        eoi,
  output logic        int_req,
  output logic [4:0]  int_vec,
  output logic        vec_valid,
  output logic        in_service,
  output logic [2:0]  bank_act,
  output logic [26:0] pending
);
  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;
  state_t state, state_n;
  logic [26:0] prev, mask, eligible, vec_oh;
  logic [7:0] cnt, cnt_n;
  logic [4:0] win, vec_n;
  logic ack;
  assign eligible = pending & ~mask;
  assign vec_oh = 27'(1) << int_vec;
  assign bank_act = {|eligible[26:18], |eligible[17:9], |eligible[8:0]};
  assign int_req = state == REQ;
  assign in_service = state == SERV;
  // descending scan leaves the lowest set index as the winner
  always_comb begin
    win = '0;
    for (int i = 26; i >= 0; i--)
      if (eligible[i]) win = 5'(i);
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    vec_n = int_vec;
    ack = 1'b0;
    case (state)
      IDLE: if (|eligible) begin
        state_n = REQ;
        cnt_n = '0;
        vec_n = win;
      end
      REQ: if (int_ack) begin
        state_n = SERV;
        ack = 1'b1;
      end else if (|(mask & vec_oh) || cnt == 8'(ACK_TIMEOUT - 1)) begin
        state_n = IDLE;
      end else begin
        cnt_n = cnt + 8'd1;
      end
      SERV: state_n = eoi ? IDLE : SERV;
      default: state_n = IDLE;
    endcase
  end
  // a fresh edge on the acknowledged channel is OR-ed in after the clear, so it survives
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      int_vec <= '0;
      vec_valid <= 1'b0;
      pending <= '0;
      prev <= '0;
      mask <= '1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      int_vec <= vec_n;
      vec_valid <= ack;
      pending <= (pending & ~(ack ? vec_oh : 27'd0)) | (irq_in & ~prev);
      prev <= irq_in;
      if (mask_we) mask <= mask_wdata;
    end
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: vector table, directed corner sequences and randomized model comparison for irq_sequencer
module tb_irq_sequencer;
  localparam int TO = 4;
  logic ck = 1'b0;
  logic rst_n, mask_we, int_ack, eoi;
  logic [26:0] irq_in, mask_wdata;
  logic int_req, vec_valid, in_service;
  logic [4:0] int_vec;
  logic [2:0] bank_act;
  logic [26:0] pending;
  int tests = 0;
  int fails = 0;

  irq_sequencer #(.ACK_TIMEOUT(TO)) dut (
    .ck(ck), .rst_n(rst_n), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .int_ack(int_ack), .eoi(eoi), .int_req(int_req), .int_vec(int_vec), .vec_valid(vec_valid),
    .in_service(in_service), .bank_act(bank_act), .pending(pending)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic rst_n;
    logic [26:0] irq;
    logic mwe;
    logic [26:0] mwd;
    logic ack;
    logic eoi;
    logic req;
    logic [4:0] vec;
    logic vv;
    logic svc;
    logic [2:0] bank;
    logic [26:0] pend;
  } row_t;
  row_t tbl[11];

  // behavioural reference: phase 0 idle, 1 requesting, 2 in service
  int phase, m_vec, m_wait;
  logic [26:0] m_pend, m_prev, m_mask;
  logic m_vv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    tick();
    rst_n = 1'b1; mask_we = 1'b1;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic pulse(input int ch);
    irq_in = 27'(1) << ch;
    tick();
    irq_in = '0;
  endtask

  task automatic serve(input int v);
    int n = 0;
    while (!int_req && n < 20) begin
      tick();
      n++;
    end
    chk("serve_req", 32'(int_req), 1);
    chk("serve_vec", 32'(int_vec), 32'(v));
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("serve_vv", 32'(vec_valid), 1);
    chk("serve_clr", 32'(pending[v]), 0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    chk("serve_eoi", 32'(in_service), 0);
  endtask

  task automatic model_step(input logic r, input logic [26:0] irq, input logic mwe,
                            input logic [26:0] mwd, input logic ack, input logic e);
    logic [26:0] elig;
    int low;
    if (!r) begin
      phase = 0; m_pend = '0; m_prev = '0; m_mask = '1; m_vec = 0; m_wait = 0; m_vv = 1'b0;
      return;
    end
    elig = m_pend & ~m_mask;
    low = -1;
    for (int i = 0; i < 27; i++)
      if (elig[i]) begin
        low = i;
        break;
      end
    m_vv = (phase == 1) && ack;
    if (m_vv) m_pend[m_vec] = 1'b0;
    m_pend = m_pend | (irq & ~m_prev);
    m_prev = irq;
    case (phase)
      0: if (low >= 0) begin phase = 1; m_vec = low; m_wait = 1; end
      1: if (ack) phase = 2;
         else if (m_mask[m_vec]) phase = 0;
         else if (m_wait == TO) phase = 0;
         else m_wait++;
      default: if (e) phase = 0;
    endcase
    if (mwe) m_mask = mwd;
  endtask

  function automatic logic [2:0] model_bank();
    logic [26:0] el = m_pend & ~m_mask;
    logic [2:0] b;
    for (int k = 0; k < 3; k++) b[k] = ((el >> (9 * k)) & 27'h1ff) != 0;
    return b;
  endfunction

  initial begin
    logic [26:0] b13 = 27'(1) << 13;
    rst_n = 1'b0; irq_in = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
    tbl[0]  = '{1'b0, 27'd0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 3'b000, 27'd0};
    tbl[1]  = '{1'b1, 27'd0, 1'b1, 27'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 3'b000, 27'd0};
    tbl[2]  = '{1'b1, b13,   1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 3'b010, b13};
    tbl[3]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 3'b010, b13};
    tbl[4]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 3'b010, b13};
    tbl[5]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b1, 1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 3'b000, 27'd0};
    tbl[6]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b1, 3'b000, 27'd0};
    tbl[7]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b0, 1'b1, 1'b0, 5'd13, 1'b0, 1'b0, 3'b000, 27'd0};
    tbl[8]  = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b1, 1'b1, 1'b0, 5'd13, 1'b0, 1'b0, 3'b000, 27'd0};
    tbl[9]  = '{1'b1, b13,   1'b1, '1,    1'b0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0, 3'b000, b13};
    tbl[10] = '{1'b1, 27'd0, 1'b0, 27'd0, 1'b0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0, 3'b000, b13};
    tick();
    foreach (tbl[r]) begin
      rst_n = tbl[r].rst_n; irq_in = tbl[r].irq; mask_we = tbl[r].mwe; mask_wdata = tbl[r].mwd;
      int_ack = tbl[r].ack; eoi = tbl[r].eoi;
      tick();
      chk($sformatf("tbl%0d_req", r), 32'(int_req), 32'(tbl[r].req));
      chk($sformatf("tbl%0d_vec", r), 32'(int_vec), 32'(tbl[r].vec));
      chk($sformatf("tbl%0d_vv", r), 32'(vec_valid), 32'(tbl[r].vv));
      chk($sformatf("tbl%0d_svc", r), 32'(in_service), 32'(tbl[r].svc));
      chk($sformatf("tbl%0d_bank", r), 32'(bank_act), 32'(tbl[r].bank));
      chk($sformatf("tbl%0d_pend", r), 32'(pending), 32'(tbl[r].pend));
    end

    // simultaneous edges are served lowest index first
    do_reset();
    irq_in = (27'(1) << 20) | (27'(1) << 9) | (27'(1) << 3);
    tick();
    irq_in = '0;
    serve(3);
    serve(9);
    serve(20);

    // unacknowledged request times out, idles one cycle, re-requests
    do_reset();
    pulse(0);
    chk("to_first", 32'(int_req), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("to_req%0d", i), 32'(int_req), ((i % 5) != 4) ? 32'd1 : 32'd0);
      chk($sformatf("to_pend%0d", i), 32'(pending[0]), 1);
      if (int_req) chk($sformatf("to_vec%0d", i), 32'(int_vec), 0);
    end

    // masking the latched channel drops the request and re-arbitrates
    do_reset();
    pulse(5);
    tick();
    chk("mk_req", 32'(int_req), 1);
    chk("mk_vec5", 32'(int_vec), 5);
    pulse(2);
    mask_we = 1'b1; mask_wdata = 27'(1) << 5;
    tick();
    mask_we = 1'b0;
    chk("mk_still", 32'(int_req), 1);
    tick();
    chk("mk_drop", 32'(int_req), 0);
    tick();
    chk("mk_req2", 32'(int_req), 1);
    chk("mk_vec2", 32'(int_vec), 2);
    chk("mk_pend5", 32'(pending[5]), 1);

    // new edge on the acknowledge cycle keeps the channel pending
    do_reset();
    pulse(7);
    tick();
    chk("re_vec", 32'(int_vec), 7);
    int_ack = 1'b1; irq_in = 27'(1) << 7;
    tick();
    int_ack = 1'b0; irq_in = '0;
    chk("re_vv", 32'(vec_valid), 1);
    chk("re_pend", 32'(pending[7]), 1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    tick();
    chk("re_req", 32'(int_req), 1);
    chk("re_vec2", 32'(int_vec), 7);

    // acknowledge wins over a mask drop and over the last timeout cycle
    do_reset();
    pulse(5);
    mask_we = 1'b1; mask_wdata = 27'(1) << 5;
    tick();
    mask_we = 1'b0; int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("pr_mask_vv", 32'(vec_valid), 1);
    chk("pr_mask_svc", 32'(in_service), 1);
    do_reset();
    pulse(6);
    tick();
    tick();
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("pr_to_vv", 32'(vec_valid), 1);

    // reset mid-REQ with ACK completes no handshake
    do_reset();
    pulse(4);
    tick();
    rst_n = 1'b0; int_ack = 1'b1;
    tick();
    rst_n = 1'b1; int_ack = 1'b0;
    chk("rq_rst_vv", 32'(vec_valid), 0);
    chk("rq_rst_pend", 32'(pending), 0);

    // reset during SERV, lines held high through release
    do_reset();
    pulse(4);
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("sv_svc", 32'(in_service), 1);
    rst_n = 1'b0; irq_in = 27'(1) << 8;
    tick();
    chk("sv_rst_req", 32'(int_req), 0);
    chk("sv_rst_vec", 32'(int_vec), 0);
    chk("sv_rst_svc", 32'(in_service), 0);
    chk("sv_rst_pend", 32'(pending), 0);
    chk("sv_rst_bank", 32'(bank_act), 0);
    rst_n = 1'b1;
    tick();
    chk("sv_rel_pend", 32'(pending), 32'(27'(1) << 8));
    irq_in = 27'(1) << 1;
    tick();
    irq_in = '0;
    chk("sv_new_pend", 32'(pending), 32'((27'(1) << 8) | 27'(2)));
    chk("sv_masked_bank", 32'(bank_act), 0);
    tick();
    tick();
    chk("sv_masked_req", 32'(int_req), 0);

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      rst_n = (c == 0 || $urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      irq_in = 27'($urandom & $urandom & $urandom);
      mask_we = $urandom_range(0, 15) == 0;
      mask_wdata = 27'($urandom & $urandom);
      int_ack = $urandom_range(0, 2) == 0;
      eoi = $urandom_range(0, 2) == 0;
      model_step(rst_n, irq_in, mask_we, mask_wdata, int_ack, eoi);
      tick();
      chk("rnd_req", 32'(int_req), (phase == 1) ? 32'd1 : 32'd0);
      chk("rnd_svc", 32'(in_service), (phase == 2) ? 32'd1 : 32'd0);
      chk("rnd_vec", 32'(int_vec), 32'(m_vec));
      chk("rnd_vv", 32'(vec_valid), 32'(m_vv));
      chk("rnd_pend", 32'(pending), 32'(m_pend));
      chk("rnd_bank", 32'(bank_act), 32'(model_bank()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16, SHALL set the number of cycles REQ waits for INT_ACK before abandoning the request (legal range 2..255).
REQ-002 CK  in  1  rising-edge clock; the sole clock.
REQ-003 RST_N  in  1  synchronous, active-low reset, sampled on CK rising edge.
REQ-004 IRQ_IN  in  27  request lines; bit 9*b+c = bank b (0..2), channel c (0..8).
REQ-005 MASK_WE  in  1  mask write strobe.
REQ-006 MASK_WDATA  in  27  mask value; 1 = channel masked.
REQ-007 INT_ACK  in  1  CPU acknowledge of INT_REQ.
REQ-008 EOI  in  1  CPU end-of-interrupt.
REQ-009 INT_REQ  out  1  interrupt request to CPU.
REQ-010 INT_VEC  out  5  winning channel index, 0..26.
REQ-011 VEC_VALID  out  1  one-cycle strobe: INT_VEC accepted by CPU.
REQ-012 IN_SERVICE  out  1  a vector is being serviced.
REQ-013 BANK_ACT  out  3  bit b = bank b has an eligible request.
REQ-014 PENDING  out  27  pending register contents.

Function
REQ-015 IRQ_IN SHALL be registered each cycle into prev; a bit SHALL set PENDING when IRQ_IN=1 and prev=0 (rising edge), on that same CK edge.
REQ-016 Eligible SHALL be PENDING & ~mask; masked pending bits SHALL remain pending.
REQ-017 The winner SHALL be the lowest-index eligible bit (bank 0 over 1 over 2; channel 0 highest within a bank).
REQ-018 BANK_ACT[b] SHALL be the OR of eligible[9b+8:9b], derived from registers only.
REQ-019 MASK_WE=1 SHALL load MASK_WDATA into mask on that edge; the new mask applies from the next cycle.
REQ-020 FSM states SHALL be IDLE, REQ, SERV.
REQ-021 IDLE: if eligible is nonzero, latch the winner into INT_VEC and go to REQ; else stay.
REQ-022 REQ: INT_REQ=1 and INT_VEC held stable; the timeout counter starts at 0 on entry and increments each cycle.
REQ-023 REQ + INT_ACK: clear the PENDING bit for INT_VEC, pulse VEC_VALID for exactly 1 cycle, go to SERV.
REQ-024 REQ, no INT_ACK, counter = ACK_TIMEOUT-1: go to IDLE with PENDING unchanged; re-arbitration follows.
REQ-025 REQ, latched channel masked (mask bit 1), no INT_ACK: go to IDLE with PENDING unchanged.
REQ-026 Precedence in REQ SHALL be INT_ACK over mask-drop over timeout.
REQ-027 SERV: IN_SERVICE=1, INT_REQ=0, INT_VEC holds the serviced index; EOI goes to IDLE.
REQ-028 INT_ACK outside REQ and EOI outside SERV SHALL be ignored.
REQ-029 A new rising edge on a channel in the same cycle its PENDING bit is cleared by INT_ACK SHALL leave the bit set (set wins).
REQ-030 Latency: IRQ_IN rises before edge k, so PENDING is set at k, INT_REQ is high after k+1 (2 cycles, unmasked, IDLE).
REQ-031 Requests arriving while in REQ/SERV SHALL accumulate in PENDING with no loss.

Reset
REQ-032 RST_N=0 at a CK edge SHALL force IDLE; PENDING=0, prev=0, mask=all ones, counter=0; INT_REQ=0, INT_VEC=0, VEC_VALID=0, IN_SERVICE=0, BANK_ACT=0.
REQ-033 Reset SHALL take effect from any state, including mid-REQ or mid-SERV, with no partial handshake completed.
REQ-034 IRQ_IN lines high when reset deasserts SHALL register as edges (prev=0) and become pending one cycle after release.

Verification
REQ-035 Mask=0, IRQ_IN[13] pulses 1 cycle -> INT_REQ=1 two cycles later with INT_VEC=13, BANK_ACT=3'b010; INT_ACK -> VEC_VALID 1 cycle, PENDING[13]=0, IN_SERVICE=1; EOI -> IDLE.
REQ-036 Mask=0, IRQ_IN[20], [9] and [3] rise together -> serviced in order 3, 9, 20, each after ACK+EOI.
REQ-037 ACK_TIMEOUT=4, IRQ_IN[0] pulse, no ACK -> INT_REQ high 4 cycles, drops 1 cycle (IDLE), reasserts with INT_VEC=0, PENDING[0]=1 throughout.
REQ-038 In REQ with INT_VEC=5, write mask bit 5=1 while PENDING[2] is eligible -> INT_REQ drops, then INT_REQ returns with INT_VEC=2, PENDING[5] stays 1.
REQ-039 IRQ_IN[7] re-rises on the INT_ACK cycle for vector 7 -> PENDING[7]=1 after ACK; vector 7 is served again after EOI.
REQ-040 RST_N=0 for 1 cycle during SERV -> all outputs 0, mask=all ones; with mask=all ones, new IRQ_IN edges set PENDING but INT_REQ stays 0.
